// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the ADC capture gate: FSM states, trigger
// modes and the per-sample threshold compare.
package adc_cap_pkg;

   localparam int ADC_DATA_W   = 128;
   localparam int ADC_SAMPLE_W = 16;
   localparam int ADC_SAMPLES  = ADC_DATA_W / ADC_SAMPLE_W;

   localparam logic [1:0] TRIG_IMM = 2'd0;
   localparam logic [1:0] TRIG_THR = 2'd1;
   localparam logic [1:0] TRIG_EXT = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } cap_state_e;

   // True when any signed sample of the beat is strictly above thr; sample 0 sits in the LSBs.
   function automatic logic any_above(input logic        [ADC_DATA_W-1:0]   beat,
                                      input logic signed [ADC_SAMPLE_W-1:0] thr);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < ADC_SAMPLES; i++) begin
         if ($signed(beat[i*ADC_SAMPLE_W +: ADC_SAMPLE_W]) > thr) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/adc_cap_fifo.sv
// Small elastic FIFO carrying {last, data}; read data comes straight from
// registered storage, so there is no combinational path from input to output.
module adc_cap_fifo #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_last_i,
   input  logic              set_tail_last_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_last_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [AW-1:0]   tail_ptr;

   assign tail_ptr = wr_ptr_q - 1'b1;
   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == (AW+1)'(DEPTH));

   // NOTE: every variable written here gets a default first, otherwise a path that skips it infers a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the output gating below keeps stale entries invisible.
   always_ff @(posedge clk_i) begin
      if (!flush_i) begin
         if (wr_en_i)         mem_q[wr_ptr_q]         <= {wr_last_i, wr_data_i};
         if (set_tail_last_i) mem_q[tail_ptr][DATA_W] <= 1'b1;
      end
   end

   assign rd_data_o = empty_o ? '0   : mem_q[rd_ptr_q][DATA_W-1:0];
   assign rd_last_o = empty_o ? 1'b0 : mem_q[rd_ptr_q][DATA_W];

endmodule

// File: rtl/adc_capture_gate.sv
// Per-channel ADC capture gate: arm, wait for trigger, forward a fixed number
// of beats through an elastic FIFO, and flag overflow since the source cannot stall.
module adc_capture_gate
   import adc_cap_pkg::*;
#(
   parameter int DATA_W     = ADC_DATA_W,
   parameter int SAMPLE_W   = ADC_SAMPLE_W,
   parameter int CNT_W      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                rf_clk,
   input  logic                rf_rstb,
   input  logic [DATA_W-1:0]   s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   input  logic                cfg_arm,
   input  logic                cfg_abort,
   input  logic [1:0]          cfg_trig_mode,
   input  logic [SAMPLE_W-1:0] cfg_threshold,
   input  logic                ext_trig,
   input  logic [CNT_W-1:0]    cfg_cap_beats,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [CNT_W-1:0]    beat_cnt
);

   cap_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cap_beats_q, cap_beats_d;
   logic [1:0]          mode_q, mode_d;
   logic [SAMPLE_W-1:0] thr_q, thr_d;
   logic                prev_hi_q, prev_hi_d;
   logic                ext_d_q;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic                done_q, done_d;
   logic                overflow_q, overflow_d;

   logic             fifo_wr, fifo_wr_last, fifo_set_last, fifo_flush;
   logic             fifo_rd, fifo_full, fifo_empty;
   logic             beat_above, trig_hit;
   logic [CNT_W-1:0] cnt_inc;

   assign beat_above = any_above(s_axis_tdata, thr_q);
   assign cnt_inc    = beat_cnt_q + CNT_W'(1);
   assign fifo_rd    = m_axis_tvalid & m_axis_tready;

   always_comb begin
      trig_hit = 1'b1;
      unique case (mode_q)
         TRIG_THR: trig_hit = beat_above & ~prev_hi_q;
         TRIG_EXT: trig_hit = ext_trig & ~ext_d_q;
         default:  trig_hit = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cap_beats_d   = cap_beats_q;
      mode_d        = mode_q;
      thr_d         = thr_q;
      prev_hi_d     = prev_hi_q;
      beat_cnt_d    = beat_cnt_q;
      done_d        = done_q;
      overflow_d    = overflow_q;
      fifo_wr       = 1'b0;
      fifo_wr_last  = 1'b0;
      fifo_set_last = 1'b0;
      fifo_flush    = 1'b0;

      if (cfg_abort) begin
         state_d    = IDLE;
         fifo_flush = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cfg_arm) begin
                  cap_beats_d = cfg_cap_beats;
                  mode_d      = cfg_trig_mode;
                  thr_d       = cfg_threshold;
                  prev_hi_d   = 1'b0;
                  beat_cnt_d  = '0;
                  overflow_d  = 1'b0;
                  done_d      = (cfg_cap_beats == '0);
                  if (cfg_cap_beats != '0) state_d = ARMED;
               end
            end
            ARMED: begin
               if (s_axis_tvalid) begin
                  prev_hi_d = beat_above;
                  if (trig_hit) begin
                     fifo_wr      = 1'b1;
                     beat_cnt_d   = cnt_inc;
                     fifo_wr_last = (cnt_inc == cap_beats_q);
                     state_d      = fifo_wr_last ? DRAIN : CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               if (s_axis_tvalid) begin
                  if (!fifo_full || fifo_rd) begin
                     fifo_wr    = 1'b1;
                     beat_cnt_d = cnt_inc;
                     if (cnt_inc == cap_beats_q) begin
                        fifo_wr_last = 1'b1;
                        state_d      = DRAIN;
                     end
                  end else begin
                     // Beat is lost: close the stream on the newest stored entry instead.
                     overflow_d    = 1'b1;
                     fifo_set_last = 1'b1;
                     state_d       = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge rf_clk or negedge rf_rstb) begin
      if (!rf_rstb) begin
         state_q     <= IDLE;
         cap_beats_q <= '0;
         mode_q      <= TRIG_IMM;
         thr_q       <= '0;
         prev_hi_q   <= 1'b0;
         ext_d_q     <= 1'b0;
         beat_cnt_q  <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cap_beats_q <= cap_beats_d;
         mode_q      <= mode_d;
         thr_q       <= thr_d;
         prev_hi_q   <= prev_hi_d;
         ext_d_q     <= ext_trig;
         beat_cnt_q  <= beat_cnt_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
      end
   end

   adc_cap_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i           (rf_clk),
      .rst_n_i         (rf_rstb),
      .flush_i         (fifo_flush),
      .wr_en_i         (fifo_wr),
      .wr_data_i       (s_axis_tdata),
      .wr_last_i       (fifo_wr_last),
      .set_tail_last_i (fifo_set_last),
      .rd_en_i         (fifo_rd),
      .rd_data_o       (m_axis_tdata),
      .rd_last_o       (m_axis_tlast),
      .full_o          (fifo_full),
      .empty_o         (fifo_empty)
   );

   assign m_axis_tvalid = ~fifo_empty;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign overflow      = overflow_q;
   assign beat_cnt      = beat_cnt_q;

endmodule

// File: tb/tb_adc_capture_gate.sv
// Directed bench for adc_capture_gate: a table of trigger scenarios plus
// hand-written sequences for latency, backpressure, abort, zero-length and reset.
module tb_adc_capture_gate;

   logic         rf_clk = 1'b0;
   logic         rf_rstb;
   logic [127:0] s_axis_tdata;
   logic         s_axis_tvalid;
   logic [127:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic         m_axis_tlast;
   logic         cfg_arm;
   logic         cfg_abort;
   logic [1:0]   cfg_trig_mode;
   logic [15:0]  cfg_threshold;
   logic         ext_trig;
   logic [31:0]  cfg_cap_beats;
   logic         busy;
   logic         done;
   logic         overflow;
   logic [31:0]  beat_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [128:0] out_q [$];

   typedef struct {
      string      name;
      logic [1:0] mode;
      int         cap;
      int         thr;
      logic       ext_pre;
      logic [11:0] ext_pat;
      int         samp [12];
      int         exp_first;
      int         exp_n;
   } vec_t;

   vec_t vecs [7];

   adc_capture_gate dut (
      .rf_clk        (rf_clk),
      .rf_rstb       (rf_rstb),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .cfg_arm       (cfg_arm),
      .cfg_abort     (cfg_abort),
      .cfg_trig_mode (cfg_trig_mode),
      .cfg_threshold (cfg_threshold),
      .ext_trig      (ext_trig),
      .cfg_cap_beats (cfg_cap_beats),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow),
      .beat_cnt      (beat_cnt)
   );

   always #5 rf_clk = ~rf_clk;

   // Handshakes are recorded mid-cycle, where tready/tvalid already hold the values the next edge uses.
   always @(negedge rf_clk) begin
      if (rf_rstb && m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge rf_clk);
      #1;
   endtask

   // Sample 0 carries the value under test; the other samples tag the beat index at a very negative level.
   function automatic logic [127:0] mk_beat(input int s0, input int idx);
      logic [127:0] b;
      b[15:0] = 16'(s0);
      for (int k = 1; k < 8; k++) b[k*16 +: 16] = 16'(-32768 + idx);
      return b;
   endfunction

   function automatic vec_t mk_vec(input string name, input logic [1:0] mode, input int cap,
                                   input int thr, input logic ext_pre, input logic [11:0] ext_pat,
                                   input int first, input int n);
      vec_t v;
      v.name = name;  v.mode = mode;  v.cap = cap;  v.thr = thr;
      v.ext_pre = ext_pre;  v.ext_pat = ext_pat;  v.exp_first = first;  v.exp_n = n;
      for (int i = 0; i < 12; i++) v.samp[i] = 0;
      return v;
   endfunction

   task automatic wait_idle_done(input string name);
      for (int c = 0; c < 40 && !(done && !busy); c++) step();
      check({name, " done"}, 129'(done), 129'(1));
      check({name, " busy"}, 129'(busy), 129'(0));
   endtask

   task automatic check_stream(input string name, input int first, input int n, input int base,
                               input int samp [12], input logic use_samp);
      int v;
      check({name, " beats out"}, 129'(out_q.size()), 129'(n));
      for (int k = 0; k < n && k < out_q.size(); k++) begin
         v = use_samp ? samp[first+k] : base + first + k;
         check($sformatf("%s beat%0d", name, k), out_q[k], {(k == n-1), mk_beat(v, first+k)});
      end
   endtask

   task automatic run_vec(input vec_t v);
      out_q.delete();
      cfg_trig_mode = v.mode;
      cfg_threshold = 16'(v.thr);
      cfg_cap_beats = 32'(v.cap);
      m_axis_tready = 1'b1;
      ext_trig      = v.ext_pre;
      step();
      step();
      cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
      check({v.name, " armed busy"}, 129'(busy), 129'(1));
      check({v.name, " arm clears done"}, 129'(done), 129'(0));
      for (int i = 0; i < 12; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk_beat(v.samp[i], i);
         ext_trig      = v.ext_pat[i];
         step();
      end
      s_axis_tvalid = 1'b0;
      ext_trig      = 1'b0;
      wait_idle_done(v.name);
      check_stream(v.name, v.exp_first, v.exp_n, 0, v.samp, 1'b1);
      check({v.name, " beat_cnt"}, 129'(beat_cnt), 129'(v.exp_n));
      check({v.name, " overflow"}, 129'(overflow), 129'(0));
   endtask

   initial begin
      int  dummy [12];
      logic busy_seen;

      for (int i = 0; i < 12; i++) dummy[i] = 0;
      rf_rstb = 1'b0;
      s_axis_tdata = '0;  s_axis_tvalid = 1'b0;  m_axis_tready = 1'b0;
      cfg_arm = 1'b0;  cfg_abort = 1'b0;  cfg_trig_mode = 2'd0;  cfg_threshold = '0;
      ext_trig = 1'b0;  cfg_cap_beats = '0;

      vecs[0] = mk_vec("imm",      2'd0, 4,    0,    1'b0, 12'h000, 0, 4);
      for (int i = 0; i < 12; i++) vecs[0].samp[i] = 100 + i;
      vecs[1] = mk_vec("thr",      2'd1, 3,    1000, 1'b0, 12'h000, 1, 3);
      vecs[1].samp = '{500, 1200, 1500, 300, 2000, 0, 0, 0, 0, 0, 0, 0};
      vecs[2] = mk_vec("ext",      2'd2, 3,    0,    1'b1, 12'hF80, 7, 3);
      for (int i = 0; i < 12; i++) vecs[2].samp[i] = 700 + i;
      vecs[3] = mk_vec("mode3",    2'd3, 2,    0,    1'b0, 12'h000, 0, 2);
      for (int i = 0; i < 12; i++) vecs[3].samp[i] = 30 + i;
      vecs[4] = mk_vec("thr_sign", 2'd1, 2,    -100, 1'b0, 12'h000, 2, 2);
      vecs[4].samp = '{-200, -150, 50, 60, 70, 80, 0, 0, 0, 0, 0, 0};
      vecs[5] = mk_vec("thr_first",2'd1, 2,    1000, 1'b0, 12'h000, 0, 2);
      vecs[5].samp = '{1500, 1600, 200, 1700, 1800, 0, 0, 0, 0, 0, 0, 0};
      vecs[6] = mk_vec("cap1",     2'd0, 1,    0,    1'b0, 12'h000, 0, 1);
      for (int i = 0; i < 12; i++) vecs[6].samp[i] = 900 + i;

      step();
      step();
      check("rst tvalid",   129'(m_axis_tvalid), 129'(0));
      check("rst tlast",    129'(m_axis_tlast),  129'(0));
      check("rst tdata",    129'(m_axis_tdata),  129'(0));
      check("rst busy",     129'(busy),          129'(0));
      check("rst done",     129'(done),          129'(0));
      check("rst overflow", 129'(overflow),      129'(0));
      check("rst beat_cnt", 129'(beat_cnt),      129'(0));
      rf_rstb = 1'b1;
      step();

      // First beat appears one cycle after the beat following the arm.
      out_q.delete();
      cfg_trig_mode = 2'd0;  cfg_cap_beats = 32'd4;  m_axis_tready = 1'b1;
      cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
      s_axis_tvalid = 1'b1;  s_axis_tdata = mk_beat(200, 0);
      @(negedge rf_clk);
      check("lat tvalid before", 129'(m_axis_tvalid), 129'(0));
      step();
      s_axis_tdata = mk_beat(201, 1);
      @(negedge rf_clk);
      check("lat tvalid after", 129'(m_axis_tvalid), 129'(1));
      check("lat tdata after",  129'(m_axis_tdata),  129'(mk_beat(200, 0)));
      for (int i = 2; i < 6; i++) begin
         step();
         s_axis_tdata = mk_beat(200 + i, i);
      end
      step();
      s_axis_tvalid = 1'b0;
      wait_idle_done("lat");
      check_stream("lat", 0, 4, 200, dummy, 1'b0);
      check("lat beat_cnt", 129'(beat_cnt), 129'(4));

      for (int t = 0; t < 7; t++) run_vec(vecs[t]);

      // Backpressure overruns the FIFO.
      out_q.delete();
      cfg_trig_mode = 2'd0;  cfg_cap_beats = 32'd16;  m_axis_tready = 1'b0;
      cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk_beat(300 + i, i);
         m_axis_tready = (i >= 6);
         if (i == 5) begin
            @(negedge rf_clk);
            check("bp stall tdata",   129'(m_axis_tdata), 129'(mk_beat(300, 0)));
            check("bp stall tlast",   129'(m_axis_tlast), 129'(0));
            check("bp overflow flag", 129'(overflow),     129'(1));
         end
         step();
      end
      s_axis_tvalid = 1'b0;
      wait_idle_done("bp");
      check_stream("bp", 0, 4, 300, dummy, 1'b0);
      check("bp overflow", 129'(overflow), 129'(1));
      check("bp beat_cnt", 129'(beat_cnt), 129'(4));

      // Write into a full FIFO while a read happens the same cycle.
      out_q.delete();
      cfg_cap_beats = 32'd8;  m_axis_tready = 1'b0;
      cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
      for (int i = 0; i < 12; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk_beat(400 + i, i);
         m_axis_tready = (i >= 4);
         step();
      end
      s_axis_tvalid = 1'b0;
      wait_idle_done("fullrw");
      check_stream("fullrw", 0, 8, 400, dummy, 1'b0);
      check("fullrw overflow", 129'(overflow), 129'(0));
      check("fullrw beat_cnt", 129'(beat_cnt), 129'(8));

      // Abort mid-capture, then arm and abort together from IDLE.
      cfg_cap_beats = 32'd10;  m_axis_tready = 1'b1;
      cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk_beat(500 + i, i);
         step();
      end
      check("abort pre beat_cnt", 129'(beat_cnt), 129'(5));
      s_axis_tdata = mk_beat(505, 5);
      cfg_abort = 1'b1;
      step();
      cfg_abort = 1'b0;
      s_axis_tvalid = 1'b0;
      check("abort tvalid",   129'(m_axis_tvalid), 129'(0));
      check("abort busy",     129'(busy),          129'(0));
      check("abort done",     129'(done),          129'(0));
      check("abort beat_cnt", 129'(beat_cnt),      129'(5));
      cfg_arm = 1'b1;  cfg_abort = 1'b1;  cfg_cap_beats = 32'd3;
      step();
      cfg_arm = 1'b0;  cfg_abort = 1'b0;
      check("arm+abort busy",     129'(busy),     129'(0));
      check("arm+abort beat_cnt", 129'(beat_cnt), 129'(5));

      // Zero-length capture.
      out_q.delete();
      cfg_cap_beats = 32'd0;
      cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
      check("cap0 done", 129'(done), 129'(1));
      busy_seen = busy;
      for (int i = 0; i < 5; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk_beat(600 + i, i);
         step();
         busy_seen |= busy;
      end
      s_axis_tvalid = 1'b0;
      step();
      check("cap0 busy seen", 129'(busy_seen),    129'(0));
      check("cap0 beats out", 129'(out_q.size()), 129'(0));

      // Asynchronous reset in the middle of a capture.
      cfg_cap_beats = 32'd10;  m_axis_tready = 1'b0;
      cfg_arm = 1'b1;
      step();
      cfg_arm = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk_beat(800 + i, i);
         step();
      end
      #2;
      rf_rstb = 1'b0;
      #1;
      check("mid rst tvalid",   129'(m_axis_tvalid), 129'(0));
      check("mid rst tdata",    129'(m_axis_tdata),  129'(0));
      check("mid rst tlast",    129'(m_axis_tlast),  129'(0));
      check("mid rst busy",     129'(busy),          129'(0));
      check("mid rst beat_cnt", 129'(beat_cnt),      129'(0));
      check("mid rst done",     129'(done),          129'(0));
      s_axis_tvalid = 1'b0;
      step();
      rf_rstb = 1'b1;
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/adc_capture_gate.md
Name: adc_capture_gate

Overview:
Per-channel ADC capture gate. It sits between the RF wrapper ADC AXI-Stream output and the ADC data path.
- Waits for an arm command, then for a trigger (immediate, threshold or external).
- After the trigger, forwards exactly cfg_cap_beats 128-bit beats through a small elastic FIFO, with tlast on the final beat.
- The ADC source cannot stall, so backpressure that fills the FIFO is detected and reported as overflow.

Parameters:
DATA_W, 128, stream width in bits
SAMPLE_W, 16, signed sample width; DATA_W/SAMPLE_W samples per beat, sample 0 in the LSBs
CNT_W, 32, width of the beat counter and of cfg_cap_beats
FIFO_DEPTH, 4, elastic FIFO entries; must be a power of 2 and at least 2

Ports:
rf_clk  in  1  ADC user clock; the only clock
rf_rstb  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_W  ADC samples; there is no tready, the source never stalls
s_axis_tvalid  in  1  ADC beat valid
m_axis_tdata  out  DATA_W  captured beat toward the ADC data path
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  final beat of the capture
cfg_arm  in  1  one-cycle pulse; starts a capture
cfg_abort  in  1  one-cycle pulse; cancels the capture
cfg_trig_mode  in  2  0 immediate, 1 threshold rising, 2 external, 3 reserved (treated as 0)
cfg_threshold  in  SAMPLE_W  signed threshold
ext_trig  in  1  external trigger level, already synchronous to rf_clk
cfg_cap_beats  in  CNT_W  number of beats to capture
busy  out  1  high in ARMED, CAPTURE and DRAIN
done  out  1  sticky; set at capture end, cleared by cfg_arm
overflow  out  1  sticky; cleared by cfg_arm
beat_cnt  out  CNT_W  beats accepted in the current capture

Behaviour:
Reset values:
- All outputs 0.
- FIFO empty; state IDLE.
- Previous-beat-above flag (prev_hi) 0; external-trigger previous value (ext_d) 0.

States IDLE, ARMED, CAPTURE, DRAIN:
- IDLE, cfg_arm:
  - cfg_arm latches cfg_cap_beats, cfg_trig_mode and cfg_threshold.
  - It clears done, overflow and beat_cnt.
  - If latched beats == 0: done=1 on the next cycle, state stays IDLE, no output.
  - Otherwise go to ARMED.
- ARMED: trigger is evaluated only on cycles with s_axis_tvalid=1.
  - mode 0: the first valid beat.
  - mode 1: any sample > threshold (signed compare) AND prev_hi==0. prev_hi updates on every valid beat while ARMED; it is cleared on arm.
  - mode 2: ext_trig==1 AND ext_d==0, i.e. a rising edge.
  - The trigger beat is the first captured beat. Enter CAPTURE.
- CAPTURE: every valid beat is written to the FIFO and increments beat_cnt.
  - The beat where beat_cnt reaches the latched count is written with tlast=1; go to DRAIN.
- DRAIN: when the FIFO is empty (the last beat has been handshaken), done=1 and go to IDLE.
- cfg_arm outside IDLE is ignored.

Latency:
- Accepted input beat to m_axis_tvalid: 1 cycle, registered FIFO output.
- With m_axis_tready held at 1, output runs at full input rate.

Handshake:
- Standard AXIS; m_axis_tdata and m_axis_tlast are stable while tvalid=1 and tready=0.
- FIFO write and read in the same cycle when full is allowed; occupancy is unchanged.

Overflow:
- Trigger: a valid input beat in CAPTURE while the FIFO is full and no read is occurring in that cycle.
- The beat is dropped and overflow=1.
- The tlast bit of the most recently written FIFO entry is forced to 1.
- State goes to DRAIN; beat_cnt is not incremented.

Abort:
- cfg_abort in any state: next cycle state=IDLE, FIFO flushed, m_axis_tvalid=0.
- done is not set; overflow and beat_cnt are held.
- Abort intentionally truncates the stream.
- cfg_arm and cfg_abort in the same cycle: abort wins and the arm is ignored.

Reset mid-operation: asynchronous return to reset values; the partial stream is discarded.

Counter: beat_cnt does not wrap; the count reaches the latched cfg_cap_beats before any wrap is possible.

Decomposition:
- Package adc_cap_pkg:
  - cap_state_e enum (IDLE, ARMED, CAPTURE, DRAIN).
  - Trigger mode localparams TRIG_IMM, TRIG_THR, TRIG_EXT.
  - Function any_above(beat, thr) doing the signed per-sample compare.
- Sub-module adc_cap_fifo: synchronous FIFO, FIFO_DEPTH entries of DATA_W+1 bits (data plus last).
  - Ports: wr_en, rd_en, flush, full, empty.
  - set_tail_last input: sets the last bit of the entry at wr_ptr-1.
  - Output register drives the AXIS outputs.

Test Plan:
- Immediate: mode 0, cap_beats=4, continuous valid, tready=1 -> exactly 4 beats out, first appearing 1 cycle after the arm-following beat; tlast on beat 4; done=1; beat_cnt=4.
- Threshold: thr=1000; beats with max sample 500, 1200, 1500, 300, 2000; cap_beats=3 -> captured beats are 1200, 1500, 300 (the 1500 beat is not a new trigger since prev_hi=1); tlast on 300.
- External: mode 2, ext_trig held high before arm, falls, rises on beat 7 of the input count -> capture starts at beat 7, not at arm.
- Backpressure: cap_beats=16, FIFO_DEPTH=4, tready=0 for 6 cycles after trigger -> overflow=1; 4 beats out, 4th with tlast; done=1; beat_cnt=4.
- Abort and arm: abort at beat_cnt=5 of 10 -> next cycle tvalid=0, busy=0, done=0, beat_cnt=5; arm plus abort in the same cycle from IDLE -> stays IDLE.
- cap_beats=0 arm -> done=1 one cycle later, busy never asserted, no output; rf_rstb low mid-CAPTURE -> all outputs 0 immediately.
